// File: rtl/c64_clk_pkg.sv
// Shared types and constants for the C64 clock sequencer.
package c64_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } clkseq_state_e;

  localparam int unsigned PHASE_W           = 5;
  localparam logic [PHASE_W-1:0] PHI2_RISE_PHASE = 5'd15;
  localparam logic [PHASE_W-1:0] PHI2_FALL_PHASE = 5'd31;
  localparam int unsigned PAL_STALL_INC_DEF = 2402;

endpackage

// File: rtl/c64_sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
module c64_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/c64_clk_sequencer.sv
// PLL-lock gated core reset and phi2 bus-phase enables for a C64 core.
// Optional lock-loss event counter is enabled by defining CLKSEQ_LOCK_LOSS_CNT_EN.
module c64_clk_sequencer
  import c64_clk_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 4096,
  parameter int unsigned PAL_STALL_INC = PAL_STALL_INC_DEF
) (
  input  logic               clk32_i,
  input  logic               reset_i,
  input  logic               pll_locked_i,
  input  logic               pal_i,
  output logic               sys_reset_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               phi2_o,
  output logic               phi2_rise_en_o,
  output logic               phi2_fall_en_o
`ifdef CLKSEQ_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0]         lock_loss_cnt_o
`endif
);

  localparam logic [1:0] StWaitLock = WAIT_LOCK;
  localparam logic [1:0] StHold     = HOLD;
  localparam logic [1:0] StRun      = RUN;

  localparam int unsigned HoldW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [15:0] PalInc = 16'(PAL_STALL_INC);

  logic               locked_s;
  logic [1:0]         state_q, state_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [15:0]        acc_q, acc_d;
  logic [16:0]        acc_sum;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phi2_q;
  logic               sys_reset_q;
  logic               run, stall, adv;

  c64_sync2 u_lock_sync (
    .clk_i (clk32_i),
    .rst_i (reset_i),
    .d_i   (pll_locked_i),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      StWaitLock: begin
        hold_d = '0;
        if (locked_s) state_d = StHold;
      end
      StHold: begin
        if (!locked_s) begin
          state_d = StWaitLock;
          hold_d  = '0;
        end else if (hold_q == HoldLast) begin
          state_d = StRun;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StRun: begin
        hold_d = '0;
        if (!locked_s) state_d = StWaitLock;
      end
      default: begin
        state_d = StWaitLock;
        hold_d  = '0;
      end
    endcase
  end

  // PAL stretches the period by skipping phase advance on accumulator carry-out.
  assign run     = (state_q == StRun);
  assign acc_sum = {1'b0, acc_q} + {1'b0, PalInc};
  assign stall   = run & pal_i & acc_sum[16];
  assign adv     = run & ~stall;

  always_comb begin
    acc_d = '0;
    if (run && pal_i && (state_d == StRun)) acc_d = acc_sum[15:0];
  end

  // Phase follows next state so it already reads 0 in the first non-RUN cycle.
  always_comb begin
    phase_d = phase_q;
    if (state_d != StRun) begin
      phase_d = '0;
    end else if (adv) begin
      phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk32_i) begin
    if (reset_i) begin
      state_q     <= StWaitLock;
      hold_q      <= '0;
      acc_q       <= '0;
      phase_q     <= '0;
      phi2_q      <= 1'b0;
      sys_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      phi2_q      <= phase_d[PHASE_W-1];
      sys_reset_q <= (state_d != StRun);
    end
  end

  assign sys_reset_o    = sys_reset_q;
  assign phase_o        = phase_q;
  assign phi2_o         = phi2_q;
  assign phi2_rise_en_o = adv & (phase_q == PHI2_RISE_PHASE);
  assign phi2_fall_en_o = adv & (phase_q == PHI2_FALL_PHASE);

`ifdef CLKSEQ_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (run && (state_d == StWaitLock) && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk32_i) begin
    if (reset_i) begin
      loss_cnt_q <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_c64_clk_sequencer.sv
// Self-checking bench for c64_clk_sequencer: vector table, directed corner cases and
// randomized stimulus against a streak/arithmetic reference model.
module tb_c64_clk_sequencer;

  localparam int unsigned HOLD = 16;
  localparam longint      INC  = 2402;

  logic       clk = 1'b0;
  logic       reset, pll_locked, pal;
  logic       sys_reset, phi2, rise_en, fall_en;
  logic [4:0] phase;
`ifdef CLKSEQ_LOCK_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  c64_clk_sequencer #(
    .HOLD_CYCLES   (HOLD),
    .PAL_STALL_INC (2402)
  ) dut (
    .clk32_i        (clk),
    .reset_i        (reset),
    .pll_locked_i   (pll_locked),
    .pal_i          (pal),
    .sys_reset_o    (sys_reset),
    .phase_o        (phase),
    .phi2_o         (phi2),
    .phi2_rise_en_o (rise_en),
    .phi2_fall_en_o (fall_en)
`ifdef CLKSEQ_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt_o (loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: running in RUN means locked_s has been high for more than HOLD edges.
  bit     m_dly[$] = '{1'b0, 1'b0};
  int     m_streak = 0;
  longint m_nadv   = 0;
  longint m_npal   = 0;
  int     m_llc    = 0;

  function automatic bit m_run();
    return m_streak > int'(HOLD);
  endfunction

  function automatic bit m_stall();
    return m_run() && pal && ((((m_npal + 1) * INC) >> 16) != ((m_npal * INC) >> 16));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [4:0] ph;
    logic       st;
    ph = m_run() ? 5'(m_nadv % 32) : 5'd0;
    st = m_stall();
    chk("model", {sys_reset, phase, phi2, rise_en, fall_en},
        {!m_run(), ph, ph >= 5'd16, m_run() && !st && ph == 5'd15,
         m_run() && !st && ph == 5'd31});
`ifdef CLKSEQ_LOCK_LOSS_CNT_EN
    chk("model_llc", loss_cnt, m_llc);
`endif
  endtask

  task automatic model_edge();
    bit was_run, now_run, st;
    if (reset) begin
      m_dly = '{1'b0, 1'b0};
      m_streak = 0;
      m_nadv = 0;
      m_npal = 0;
      m_llc = 0;
      return;
    end
    was_run  = m_run();
    st       = m_stall();
    m_streak = m_dly[0] ? m_streak + 1 : 0;
    now_run  = m_run();
    if (was_run && !now_run && m_llc < 255) m_llc++;
    m_nadv = now_run ? m_nadv + ((was_run && !st) ? 1 : 0) : 0;
    m_npal = (was_run && now_run && pal) ? m_npal + 1 : 0;
    void'(m_dly.pop_front());
    m_dly.push_back(pll_locked);
  endtask

  // Compare at the negedge, then step past the next posedge; inputs change only afterwards.
  task automatic tick();
    @(negedge clk);
    check_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
  endtask

  typedef struct {
    int         k;
    logic       sr;
    logic [4:0] ph;
    logic       p2;
    logic       re;
    logic       fe;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int k, nr, nf, lr, lf, nadv, nstall, bad_en, n, pulses;
    logic [4:0] ph0;
    logic       e0;
    bit         found;

    vecs[0] = '{0,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{18, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[2] = '{19, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[3] = '{20, 1'b0, 5'd1,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{34, 1'b0, 5'd15, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{35, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{50, 1'b0, 5'd31, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{51, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0};
    vecs[8] = '{66, 1'b0, 5'd15, 1'b0, 1'b1, 1'b0};

    reset = 1'b1;
    pll_locked = 1'b1;
    pal = 1'b0;

    // Power-up timeline from reset release, NTSC.
    do_reset();
    k = 0;
    foreach (vecs[i]) begin
      while (k < vecs[i].k) begin
        tick();
        k++;
      end
      chk($sformatf("vec%0d_k%0d", i, vecs[i].k), {sys_reset, phase, phi2, rise_en, fall_en},
          {vecs[i].sr, vecs[i].ph, vecs[i].p2, vecs[i].re, vecs[i].fe});
    end

    // NTSC: 320 cycles give 10 of each pulse, 32 apart.
    nr = 0; nf = 0; lr = -1; lf = -1;
    for (int c = 0; c < 320; c++) begin
      if (rise_en) begin
        chk("ntsc_rise_phase", phase, 15);
        if (lr >= 0) chk("ntsc_rise_gap", c - lr, 32);
        lr = c;
        nr++;
      end
      if (fall_en) begin
        chk("ntsc_fall_phase", phase, 31);
        if (lf >= 0) chk("ntsc_fall_gap", c - lf, 32);
        lf = c;
        nf++;
      end
      tick();
    end
    chk("ntsc_rise_cnt", nr, 10);
    chk("ntsc_fall_cnt", nf, 10);

    // PAL: one full accumulator period.
    pal = 1'b1;
    nadv = 0; nstall = 0; bad_en = 0;
    for (int c = 0; c < 65536; c++) begin
      ph0 = phase;
      e0  = rise_en | fall_en;
      tick();
      if (phase != ph0) nadv++;
      else begin
        nstall++;
        if (e0) bad_en++;
      end
    end
    chk("pal_stalls", nstall, 2402);
    chk("pal_advances", nadv, 63134);
    chk("pal_enable_on_stall", bad_en, 0);
    pal = 1'b0;

    // Lock loss at phase 20.
    found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      if (phase == 5'd20) found = 1'b1;
      else tick();
    end
    chk("lockloss_find_phase20", found, 1);
    pll_locked = 1'b0;
    tick();
    chk("lockloss_e1_sysrst", sys_reset, 0);
    tick();
    chk("lockloss_e2_sysrst", sys_reset, 0);
    tick();
    chk("lockloss_e3", {sys_reset, phase}, {1'b1, 5'd0});
    pll_locked = 1'b1;
    n = 0; pulses = 0;
    while (sys_reset && n < 100) begin
      if (rise_en | fall_en) pulses++;
      tick();
      n++;
    end
    chk("relock_release_cycles", n, 19);
    chk("relock_no_pulses", pulses, 0);
    chk("relock_phase", phase, 0);

    // Glitch during HOLD restarts the hold count.
    do_reset();
    repeat (10) tick();
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    repeat (18) tick();
    chk("glitch_k31_sysrst", sys_reset, 1);
    tick();
    chk("glitch_k32_sysrst", sys_reset, 0);

    // Randomized lock drops, PAL toggles and resets.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(199) == 0);
      if (pll_locked) pll_locked = ($urandom_range(59) != 0);
      else pll_locked = ($urandom_range(2) == 0);
      if ($urandom_range(99) == 0) pal = ~pal;
      tick();
    end
    reset = 1'b0;

`ifdef CLKSEQ_LOCK_LOSS_CNT_EN
    do_reset();
    for (int ev = 0; ev < 260; ev++) begin
      pll_locked = 1'b1;
      n = 0;
      while (sys_reset && n < 40) begin
        tick();
        n++;
      end
      if (sys_reset) chk("llc_lock_timeout", sys_reset, 0);
      pll_locked = 1'b0;
      n = 0;
      while (!sys_reset && n < 10) begin
        tick();
        n++;
      end
      if (!sys_reset) chk("llc_loss_timeout", sys_reset, 1);
    end
    chk("llc_saturated", loss_cnt, 255);
    reset = 1'b1;
    tick();
    chk("llc_after_reset", loss_cnt, 0);
    reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
